bus_arbiter_rr: RTL and testbench

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arbiter_rr_pkg.sv | 35 +++
 rtl/bus_arbiter_rr_pick.sv | 39 +++
 rtl/bus_arbiter_rr.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr_pkg
// Shared definitions for the five-way round-robin bus arbiter:
//   NUM_REQ     number of requesters
//   GRANT_NONE  grant vector meaning "no owner"
//   idx_t       3-bit binary requester index (0..4)
//   state_e     arbiter FSM encoding (IDLE, OWNED)
//   rr_next     index successor with wrap-around 4 -> 0
//   req_bit     bit position of a requester inside req/grant
//               (requester 0 is the MSB, requester 4 is the LSB)
// -----------------------------------------------------------------------------
package bus_arbiter_rr_pkg;

   localparam int NUM_REQ = 5;

   localparam logic [NUM_REQ-1:0] GRANT_NONE = 5'b00000;

   typedef logic [2:0] idx_t;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_e;

   // Next index in round-robin order, wrapping after the last requester.
   function automatic idx_t rr_next(input idx_t i);
      return (i == idx_t'(NUM_REQ - 1)) ? idx_t'(0) : i + idx_t'(1);
   endfunction

   // Requester i lives at bit (NUM_REQ-1-i) of req and grant.
   function automatic idx_t req_bit(input idx_t i);
      return idx_t'(NUM_REQ - 1) - i;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search. Starting one past `pointer`, walks
// the requesters in round-robin order (pointer+1, pointer+2, ... mod 5, with
// `pointer` itself examined last) and returns the first one whose req bit is 1.
//   req     in   request vector, requester 0 at the MSB
//   pointer in   last granted index; search begins at its successor
//   found   out  1 when any requester is asserting
//   index   out  binary index of the chosen requester (0 when none)
//   onehot  out  chosen requester as a one-hot vector in req bit order
// -----------------------------------------------------------------------------
module rr_pick
   import bus_arbiter_rr_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  idx_t               pointer,
   output logic               found,
   output idx_t               index,
   output logic [NUM_REQ-1:0] onehot
);

   idx_t cand;

   always_comb begin
      found  = 1'b0;
      index  = '0;
      onehot = GRANT_NONE;
      cand   = rr_next(pointer);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[req_bit(cand)]) begin
            found                 = 1'b1;
            index                 = cand;
            onehot[req_bit(cand)] = 1'b1;
         end
         cand = rr_next(cand);
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
// Five-requester round-robin bus arbiter with registered one-hot grant.
// The owner keeps the bus while its request stays high; when it drops, the
// next requester in round-robin order takes over on the same edge.
//
// Optional feature, macro ARB_TIMEOUT_EN: a hold counter limits an owner to
// MAX_HOLD consecutive grant cycles while someone else is waiting. Without
// the macro the owner holds indefinitely and MAX_HOLD has no effect.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req[4:0]   in   request lines, req[4]=requester 0 ... req[0]=requester 4
//   grant[4:0] out  registered one-hot grant, same bit order as req
//   owner[2:0] out  registered binary index of owner, 0 when idle
//   busy       out  registered, 1 exactly when grant is non-zero
//   state_dbg  out  current FSM state
//
// Handshake: a requester raises its req bit and keeps it high; it owns the
// bus for every cycle its grant bit is 1 and releases by dropping req.
// Only the req value present at a rising edge is considered.
// -----------------------------------------------------------------------------
module bus_arbiter_rr
   import bus_arbiter_rr_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output idx_t               owner,
   output logic               busy,
   output state_e             state_dbg
);

   if (MAX_HOLD < 1) begin : g_hold_check
      $error("bus_arbiter_rr: MAX_HOLD must be at least 1");
   end

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   idx_t               owner_q, owner_d;
   logic               busy_q,  busy_d;
   idx_t               ptr_q,   ptr_d;

   logic               owner_req;
   logic               hold_expired;
   logic               take_next;

   logic               pick_found;
   idx_t               pick_index;
   logic [NUM_REQ-1:0] pick_onehot;

   // ptr_q always holds the last granted index, so one picker serves both
   // the IDLE search and the hand-over from the current owner.
   rr_pick u_pick (
      .req     (req),
      .pointer (ptr_q),
      .found   (pick_found),
      .index   (pick_index),
      .onehot  (pick_onehot)
   );

   assign owner_req = |(grant_q & req);

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t HOLD_MAX  = cnt_t'(MAX_HOLD);
   localparam cnt_t HOLD_LAST = cnt_t'(MAX_HOLD - 1);

   cnt_t hold_cnt_q, hold_cnt_d;
   logic others_req;

   assign others_req = |(req & ~grant_q);

   // hold_cnt_q counts grant cycles already completed by the owner, so when
   // it equals MAX_HOLD-1 the current cycle is the MAX_HOLD-th one and the
   // coming edge may hand over. The count keeps climbing to MAX_HOLD and
   // saturates there while nobody else waits.
   assign hold_expired = (state_q == OWNED) && others_req && (hold_cnt_q >= HOLD_LAST);

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (state_d != OWNED || grant_d != grant_q) begin
         hold_cnt_d = '0;
      end else if (hold_cnt_q != HOLD_MAX) begin
         hold_cnt_d = hold_cnt_q + cnt_t'(1);
      end
   end
`else
   assign hold_expired = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      busy_d    = busy_q;
      ptr_d     = ptr_q;
      take_next = 1'b0;

      case (state_q)
         IDLE:    take_next = 1'b1;
         OWNED:   take_next = !owner_req || hold_expired;
         default: take_next = 1'b1;
      endcase

      if (take_next) begin
         if (pick_found) begin
            state_d = OWNED;
            grant_d = pick_onehot;
            owner_d = pick_index;
            busy_d  = 1'b1;
            ptr_d   = pick_index;
         end else begin
            state_d = IDLE;
            grant_d = GRANT_NONE;
            owner_d = '0;
            busy_d  = 1'b0;
         end
      end
   end

   // Pointer resets to 4 so requester 0 is searched first after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         grant_q    <= GRANT_NONE;
         owner_q    <= '0;
         busy_q     <= 1'b0;
         ptr_q      <= idx_t'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         busy_q     <= busy_d;
         ptr_q      <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= hold_cnt_d;
`endif
      end
   end

   assign grant     = grant_q;
   assign owner     = owner_q;
   assign busy      = busy_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
// Directed bench for bus_arbiter_rr. Inputs change 1 ns after a rising edge
// or mid-cycle; outputs are sampled 1 ns after the rising edge. A negedge
// monitor checks grant/owner/busy consistency every cycle out of reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_arbiter_rr;
   import bus_arbiter_rr_pkg::*;

   logic               clk;
   logic               reset_n;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] grant;
   idx_t               owner;
   logic               busy;
   state_e             state_dbg;

   int tests_run    = 0;
   int tests_failed = 0;

   bus_arbiter_rr #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .grant     (grant),
      .owner     (owner),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Independent decode of a grant vector to the owner index.
   function automatic logic [2:0] grant_to_idx(input logic [4:0] g);
      for (int i = 0; i < 5; i++) if (g[4-i]) return 3'(i);
      return 3'd0;
   endfunction

   always @(negedge clk) begin
      if (reset_n) begin
         check("mon_onehot", 32'($onehot0(grant)), 32'd1);
         check("mon_busy", 32'(busy), 32'(|grant));
         check("mon_owner", 32'(owner), 32'(grant_to_idx(grant)));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = 5'b00000;
      step();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_owner", 32'(owner), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      @(posedge clk);
      #4 reset_n = 1'b1;
   endtask

   task automatic expect_out(input string tag, input logic [4:0] g, input logic [2:0] o);
      check({tag, "_grant"}, 32'(grant), 32'(g));
      check({tag, "_owner"}, 32'(owner), 32'(o));
      check({tag, "_busy"}, 32'(busy), 32'(g != 5'b0));
   endtask

   logic [4:0] seq_g [6] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
   logic [2:0] seq_o [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0;
      req     = 5'b00000;

      // Single requester 0, then release.
      do_reset();
      req = 5'b10000;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("single", 5'b10000, 3'd0);
      end
      req = 5'b00000;
      step();
      expect_out("single_rel", 5'b00000, 3'd0);

      // All requesting, owner drops after one cycle each: full rotation.
      do_reset();
      req = 5'b11111;
      for (int i = 0; i < 6; i++) begin
         step();
         expect_out("rotate", seq_g[i], seq_o[i]);
         req = 5'b11111 & ~seq_g[i];
      end
      req = 5'b00000;
      step();
      expect_out("rotate_end", 5'b00000, 3'd0);

      // Owner 2 holds against requester 4, then hands over on the same edge.
      do_reset();
      req = 5'b00100;
      step();
      expect_out("hold2", 5'b00100, 3'd2);
      req = 5'b00101;
      step();
      expect_out("hold2_contend", 5'b00100, 3'd2);
      req = 5'b00001;
      step();
      expect_out("hand4", 5'b00001, 3'd4);
      req = 5'b00000;
      step();
      expect_out("hand4_idle", 5'b00000, 3'd0);
      // Pointer is 4: search starts at 0, so requester 1 beats requester 4.
      req = 5'b01001;
      step();
      expect_out("ptr4_search", 5'b01000, 3'd1);
      req = 5'b00000;
      step();
      expect_out("ptr1_idle", 5'b00000, 3'd0);
      // Pointer is 1: search 2,3,4,0 wraps, requester 4 before requester 0.
      req = 5'b10001;
      step();
      expect_out("wrap_pick", 5'b00001, 3'd4);
      req = 5'b10000;
      step();
      expect_out("wrap_to0", 5'b10000, 3'd0);
      req = 5'b00000;
      step();
      expect_out("wrap_idle", 5'b00000, 3'd0);

      // A request pulse that ends before the edge is ignored.
      #1 req = 5'b01000;
      #2 req = 5'b00000;
      step();
      expect_out("pulse", 5'b00000, 3'd0);

      // Asynchronous reset mid-grant, then first grant after release.
      req = 5'b10000;
      step();
      expect_out("pre_areset", 5'b10000, 3'd0);
      #2 reset_n = 1'b0;
      #1;
      expect_out("areset", 5'b00000, 3'd0);
      #2 reset_n = 1'b1;
      req = 5'b00010;
      #1;
      expect_out("post_release", 5'b00000, 3'd0);
      step();
      expect_out("first_edge", 5'b00010, 3'd3);
      req = 5'b00000;
      step();
      expect_out("first_idle", 5'b00000, 3'd0);

`ifdef ARB_TIMEOUT_EN
      // Requesters 0 and 1 both held: alternate every 4 cycles.
      do_reset();
      req = 5'b11000;
      for (int i = 0; i < 16; i++) begin
         step();
         expect_out("timeout_alt", ((i / 4) % 2 == 0) ? 5'b10000 : 5'b01000,
                    ((i / 4) % 2 == 0) ? 3'd0 : 3'd1);
      end
      // Requester 0 alone keeps the bus well past MAX_HOLD.
      do_reset();
      req = 5'b10000;
      for (int i = 0; i < 20; i++) begin
         step();
         expect_out("timeout_solo", 5'b10000, 3'd0);
      end
      // Counter is saturated: a new waiter takes over at the next edge.
      req = 5'b11000;
      step();
      expect_out("timeout_sat", 5'b01000, 3'd1);
      req = 5'b00000;
      step();
`else
      // Without the hold limit, owner 0 keeps the bus against requester 1.
      do_reset();
      req = 5'b11000;
      for (int i = 0; i < 20; i++) begin
         step();
         expect_out("no_timeout", 5'b10000, 3'd0);
      end
      req = 5'b01000;
      step();
      expect_out("no_timeout_rel", 5'b01000, 3'd1);
      req = 5'b00000;
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
